// File: rtl/mul.sv
// Iterative shift-and-add unsigned fixed-point multiplier.
// Retires one multiplier bit per clock; the result is held until the next start.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | waiting for i_start; last result (if any) held on outputs
//  RUN    | one shift-add step per clock, WIDTH steps in total
module mul #(
    parameter int WIDTH = 8,
    parameter int FBITS = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_valid,
    output logic                 o_ovf,
    input  logic [WIDTH-1:0]     i_x,
    input  logic [WIDTH-1:0]     i_y,
    output logic [WIDTH-1:0]     o_p,
    output logic [2*WIDTH-1:0]   o_p_full
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]         state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH-1:0]   acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]   mq_nxt;
    logic [2*WIDTH-1:0] full_nxt;

    // The add carry lands in the accumulator MSB as {acc, mq} shifts right.
    always_comb begin
        sum      = {1'b0, acc} + {1'b0, (mq[0] ? mcand : {WIDTH{1'b0}})};
        acc_nxt  = sum[WIDTH:1];
        mq_nxt   = {sum[0], mq[WIDTH-1:1]};
        full_nxt = {acc_nxt, mq_nxt};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            mcand    <= '0;
            mq       <= '0;
            acc      <= '0;
            cnt      <= '0;
            o_busy   <= 1'b0;
            o_valid  <= 1'b0;
            o_ovf    <= 1'b0;
            o_p      <= '0;
            o_p_full <= '0;
        end else if (i_start) begin
            state   <= S_RUN;
            mcand   <= i_x;
            mq      <= i_y;
            acc     <= '0;
            cnt     <= '0;
            o_busy  <= 1'b1;
            o_valid <= 1'b0;
            o_ovf   <= 1'b0;
        end else if (state == S_RUN) begin
            acc <= acc_nxt;
            mq  <= mq_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) begin
                state    <= S_IDLE;
                o_busy   <= 1'b0;
                o_valid  <= 1'b1;
                o_p_full <= full_nxt;
                o_p      <= full_nxt[WIDTH+FBITS-1:FBITS];
                o_ovf    <= |full_nxt[2*WIDTH-1:WIDTH+FBITS];
            end
        end
    end

endmodule

// File: tb/tb_mul.sv
// Bench for mul: an integer instance and a Q4.4 instance run side by side,
// checked against arithmetic reference values.
module tb_mul;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] x0, y0, x1, y1;

    logic        busy0, valid0, ovf0;
    logic [7:0]  p0;
    logic [15:0] full0;
    logic        busy1, valid1, ovf1;
    logic [7:0]  p1;
    logic [15:0] full1;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] e_full0, e_full1;
    logic [7:0]  e_p0, e_p1;
    logic        e_ovf0, e_ovf1;

    mul #(.WIDTH(8), .FBITS(0)) u_q0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_busy(busy0), .o_valid(valid0), .o_ovf(ovf0),
        .i_x(x0), .i_y(y0), .o_p(p0), .o_p_full(full0)
    );

    mul #(.WIDTH(8), .FBITS(4)) u_q4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_busy(busy1), .o_valid(valid1), .o_ovf(ovf1),
        .i_x(x1), .i_y(y1), .o_p(p1), .o_p_full(full1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact product, then take the integer-aligned window.
    task automatic model(input int xa, input int ya, input int fb,
                         output logic [15:0] full, output logic [7:0] p, output logic ovf);
        int prod;
        prod = xa * ya;
        full = prod[15:0];
        p    = 8'((prod >> fb) % 256);
        ovf  = (prod >> (8 + fb)) != 0;
    endtask

    // Called at a negedge; start is sampled on the following posedge.
    task automatic pulse(input logic [7:0] a0, input logic [7:0] b0,
                         input logic [7:0] a1, input logic [7:0] b1);
        model(int'(a0), int'(b0), 0, e_full0, e_p0, e_ovf0);
        model(int'(a1), int'(b1), 4, e_full1, e_p1, e_ovf1);
        x0 = a0; y0 = b0; x1 = a1; y1 = b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_result();
        for (int i = 0; i < 8; i++) begin
            chk("busy_phase", {busy0, valid0, busy1, valid1}, 4'b1010);
            @(negedge clk);
        end
        chk("done_flags", {busy0, valid0, busy1, valid1}, 4'b0101);
        chk("q0_result", {ovf0, p0, full0}, {e_ovf0, e_p0, e_full0});
        chk("q4_result", {ovf1, p1, full1}, {e_ovf1, e_p1, e_full1});
    endtask

    task automatic run_both(input logic [7:0] a0, input logic [7:0] b0,
                            input logic [7:0] a1, input logic [7:0] b1);
        @(negedge clk);
        pulse(a0, b0, a1, b1);
        wait_result();
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        repeat (2) @(negedge clk);
        chk("reset_q0", {busy0, valid0, ovf0, p0, full0}, 27'd0);
        chk("reset_q4", {busy1, valid1, ovf1, p1, full1}, 27'd0);
        rst_n = 1'b1;

        run_both(8'd13,  8'd11,  8'h28, 8'h18);
        run_both(8'd20,  8'd20,  8'h80, 8'h20);
        run_both(8'd255, 8'd255, 8'hFF, 8'hFF);
        run_both(8'd0,   8'd200, 8'h10, 8'h01);

        for (int n = 0; n < 20; n++)
            run_both(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        // Operands may change freely once a result is held.
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            x0 = 8'($urandom); y0 = 8'($urandom);
            x1 = 8'($urandom); y1 = 8'($urandom);
            chk("hold_q0", {valid0, ovf0, p0, full0}, {1'b1, e_ovf0, e_p0, e_full0});
            chk("hold_q4", {valid1, ovf1, p1, full1}, {1'b1, e_ovf1, e_p1, e_full1});
        end

        // Restart three cycles into an operation.
        @(negedge clk);
        pulse(8'd13, 8'd11, 8'h28, 8'h18);
        chk("restart_novalid", {valid0, valid1}, 2'b00);
        @(negedge clk);
        chk("restart_novalid", {valid0, valid1}, 2'b00);
        @(negedge clk);
        chk("restart_novalid", {valid0, valid1}, 2'b00);
        pulse(8'd7, 8'd6, 8'h30, 8'h11);
        wait_result();
        chk("restart_p", {24'd0, p0}, 32'd42);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        pulse(8'd13, 8'd11, 8'h28, 8'h18);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_q0", {busy0, valid0, ovf0, p0, full0}, 27'd0);
        chk("async_rst_q4", {busy1, valid1, ovf1, p1, full1}, 27'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {busy0, valid0, busy1, valid1}, 4'b0000);
        end

        run_both(8'd20, 8'd20, 8'h28, 8'h18);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
